load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL take these parameters, one per line (name, default, meaning):
- XLEN, 32, data width.
- ALEN, 32, address width.
- LED_WIDTH, 4, LED register width.
- MMIO_LED_ADDR, 32'hFFFF_FFF0, LED register byte address.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I memory funct3 (byte/half/word/lbu/lhu).
- req_addr  in  ALEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  XLEN  formatted load data (0 for stores and errors).
- resp_error  out  1  misaligned or illegal funct3.
- dmem_en  out  1  RAM access enable.
- dmem_we  out  4  RAM byte write enables.
- dmem_addr  out  ALEN  word-aligned RAM address.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rdata  in  XLEN  RAM read data, valid the cycle after dmem_en with dmem_we=0.
- led_out  out  LED_WIDTH  LED register.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted in cycle N when req_valid and req_ready are both 1.
REQ-005 In cycle N, dmem_en, dmem_we, dmem_addr and dmem_wdata SHALL be driven combinationally from the request; in all other cycles dmem_en=0 and dmem_we=0.
REQ-006 dmem_addr SHALL equal {req_addr[ALEN-1:2], 2'b00}.
REQ-007 Byte enables and store data SHALL follow the access width:
- SB: dmem_we = 1<<addr[1:0], byte replicated to all 4 lanes.
- SH: dmem_we = 4'b0011 if addr[1]=0, else 4'b1100; halfword replicated to both halves.
- SW: dmem_we = 4'b1111.
REQ-008 A request SHALL be an error when any of the following holds:
- halfword access with addr[0]=1;
- word access with addr[1:0]≠0;
- load funct3 ∈ {011,110,111};
- store funct3 ∉ {000,001,010}.
REQ-009 An error request SHALL cause no RAM access and no LED write; the FSM goes IDLE→RESP and presents resp_valid=1, resp_error=1, resp_rdata=0 in cycle N+1.
REQ-010 An address is MMIO when {req_addr[ALEN-1:2],2'b00} equals MMIO_LED_ADDR; an MMIO access SHALL keep dmem_en=0.
REQ-011 An MMIO store with byte lane 0 enabled SHALL load led_out with dmem_wdata[LED_WIDTH-1:0] at the end of cycle N; with lane 0 disabled, led_out SHALL be unchanged.
REQ-012 A valid store SHALL go IDLE→RESP and present resp_valid=1, resp_error=0, resp_rdata=0 in cycle N+1.
REQ-013 A valid load SHALL go IDLE→LOAD_WAIT→RESP, with resp_valid=1 in cycle N+2.
REQ-014 The source word for a load SHALL be dmem_rdata, or for MMIO the zero-extended led_out; it SHALL be registered at the end of LOAD_WAIT.
REQ-015 Load formatting SHALL use the registered address offset:
- LB/LBU: byte at addr[1:0], sign/zero-extended.
- LH/LHU: halfword at addr[1], sign/zero-extended.
- LW: whole word.
REQ-016 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until resp_ready=1; the FSM then goes RESP→IDLE and resp_valid=0 in the next cycle.
REQ-017 A request presented during LOAD_WAIT or RESP SHALL be ignored until IDLE; the minimum spacing is 2 cycles per store and 3 cycles per load.
REQ-018 Outputs SHALL never be X after reset; with no access in flight, dmem_wdata and dmem_addr SHALL be 0.

Reset
REQ-019 rst_n=0 SHALL immediately force all of the following, regardless of clk:
- state = IDLE;
- resp_valid = 0, resp_error = 0, resp_rdata = 0;
- led_out = 0;
- dmem_en = 0, dmem_we = 0.
REQ-020 Reset in LOAD_WAIT or RESP SHALL discard the pending response; the first post-reset cycle SHALL have req_ready=1.

Verification
REQ-021 SB to addr 0x102, wdata 0x000000A5 -> in cycle N: dmem_we=4'b0100, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100; resp_valid in N+1, resp_error=0.
REQ-022 LB from 0x103 with dmem_rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80 in N+2; LBU from the same address -> 0x00000080; LH from 0x102 -> 0xFFFF80FF.
REQ-023 LW from 0x101 -> dmem_en=0, resp_error=1, resp_rdata=0 in N+1; SH to 0x003 -> dmem_we=0, resp_error=1.
REQ-024 SW 0x0000000B to 0xFFFFFFF0 -> led_out=4'hB from N+1, dmem_en=0; then LW from 0xFFFFFFF0 -> resp_rdata=0x0000000B.
REQ-025 Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable all 5 cycles and req_ready=0; after resp_ready=1 -> IDLE, with req_ready=1 the next cycle.
REQ-026 rst_n asserted during LOAD_WAIT -> resp_valid never rises, led_out=0; after release, a new SW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one request at a time into a byte-lane RAM access
// or an LED register access, then hands back a formatted, held response.
module load_store_unit #(
    parameter int              XLEN          = 32,
    parameter int              ALEN          = 32,
    parameter int              LED_WIDTH     = 4,
    parameter logic [ALEN-1:0] MMIO_LED_ADDR = 32'hFFFF_FFF0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ALEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_error,
    output logic                 dmem_en,
    output logic [3:0]           dmem_we,
    output logic [ALEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic [LED_WIDTH-1:0] led_out
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            access_ok;
    logic            err;
    logic            mmio;
    logic [3:0]      byte_en;
    logic [ALEN-1:0] word_addr;
    logic [XLEN-1:0] store_data;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic            mmio_q;
    logic            error_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign accept    = req_valid && (state == IDLE);
    assign access_ok = accept && !err;

    // Request decode: width from funct3[1:0]; funct3[2] is the unsigned flag, legal only on loads
    always_comb begin
        word_addr  = {req_addr[ALEN-1:2], 2'b00};
        mmio       = (word_addr == MMIO_LED_ADDR);
        err        = 1'b0;
        byte_en    = 4'b0000;
        store_data = '0;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << req_addr[1:0];
                store_data = {(XLEN/8){req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {(XLEN/16){req_wdata[15:0]}};
                err        = req_addr[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                store_data = req_wdata;
                err        = |req_addr[1:0];
            end
            default: err = 1'b1;
        endcase
        if (req_we && req_funct3[2])
            err = 1'b1;
        if (!req_we && (req_funct3 == 3'b110))
            err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = (req_we || err) ? RESP : LOAD_WAIT;
            LOAD_WAIT: state_next = RESP;
            RESP:      if (resp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_error = resp_valid && error_q;
        dmem_en    = access_ok && !mmio;
        dmem_we    = (access_ok && !mmio && req_we) ? byte_en : 4'b0000;
        dmem_addr  = access_ok ? word_addr : '0;
        dmem_wdata = (access_ok && req_we) ? store_data : '0;
    end

    // Load formatting works on the offset and funct3 captured at acceptance
    always_comb begin
        load_word = mmio_q ? {{(XLEN-LED_WIDTH){1'b0}}, led_out} : dmem_rdata;
        byte_sel  = load_word[{off_q, 3'b000} +: 8];
        half_sel  = load_word[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, half_sel};
            default: load_fmt = load_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            mmio_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            led_out  <= '0;
        end else begin
            if (accept) begin
                off_q    <= req_addr[1:0];
                funct3_q <= req_funct3;
                mmio_q   <= mmio;
                error_q  <= err;
                rdata_q  <= '0;
            end else if (state == LOAD_WAIT) begin
                rdata_q  <= load_fmt;
            end
            if (access_ok && req_we && mmio && byte_en[0])
                led_out <= store_data[LED_WIDTH-1:0];
        end
    end

endmodule
